cam_capture: RTL and testbench



---
 rtl/cam_capture.sv | 252 +++++++++++++++++++++++++
 tb/tb_cam_capture.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// cam_capture: DVP camera pixel capture in the sensor pixel-clock domain.
// Registers the sensor bus once, then packs DATA_W-wide beats MSB-first into
// PIX_W-wide pixels. It skips a number of frames after reset, applies a
// frame-synchronous crop window, and marks the start of each frame. It also
// reports line ends, completed frames and lines that end on a partial pixel.
module cam_capture #(
    parameter int DATA_W      = 8,
    parameter int PIX_W       = 16,
    parameter int CNT_W       = 12,
    parameter int SKIP_FRAMES = 10
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              cfg_crop_en,
    input  logic [CNT_W-1:0]  cfg_h_start,
    input  logic [CNT_W-1:0]  cfg_h_end,
    input  logic [CNT_W-1:0]  cfg_v_start,
    input  logic [CNT_W-1:0]  cfg_v_end,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_wr_en,
    output logic              m_sof,
    output logic              line_done,
    output logic [15:0]       frame_cnt,
    output logic              err_partial
);

    localparam int BYTES     = PIX_W / DATA_W;
    localparam int PH_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SKIP_W    = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam int LAST_SKIP = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;

    typedef enum logic [1:0] {
        ST_SKIP,
        ST_WAIT_VS,
        ST_ACTIVE
    } state_e;

    // Input staging registers and their one-cycle-delayed copies
    logic              vs_q, vs_dly_q;
    logic              hr_q, hr_dly_q;
    logic [DATA_W-1:0] d_q;

    // FSM, counters and packing state
    state_e            state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic [PIX_W-1:0]  pack_q, pack_d;
    logic              sof_pend_q, sof_pend_d;

    // Window shadow registers, loaded only when a frame becomes active
    logic              crop_en_s_q, crop_en_s_d;
    logic [CNT_W-1:0]  h_start_s_q, h_start_s_d;
    logic [CNT_W-1:0]  h_end_s_q, h_end_s_d;
    logic [CNT_W-1:0]  v_start_s_q, v_start_s_d;
    logic [CNT_W-1:0]  v_end_s_q, v_end_s_d;

    // Registered outputs
    logic [PIX_W-1:0]  m_data_q, m_data_d;
    logic              m_wr_en_q, m_wr_en_d;
    logic              m_sof_q, m_sof_d;
    logic              line_done_q, line_done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              err_partial_q, err_partial_d;

    // Combinational helpers
    logic              vs_rise, vs_fall, hr_rise, hr_fall;
    logic [PH_W-1:0]   ph_eff;
    logic [CNT_W-1:0]  x_eff;
    logic [PIX_W-1:0]  pix;
    logic              in_win;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign vs_rise = vs_q & ~vs_dly_q;
    assign vs_fall = ~vs_q & vs_dly_q;
    assign hr_rise = hr_q & ~hr_dly_q;
    assign hr_fall = ~hr_q & hr_dly_q;

    // Register the sensor pins once and keep a delayed copy for edge detection.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vs_q     <= 1'b0;
            vs_dly_q <= 1'b0;
            hr_q     <= 1'b0;
            hr_dly_q <= 1'b0;
            d_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            vs_q     <= cam_vsync;
            vs_dly_q <= vs_q;
            hr_q     <= cam_href;
            hr_dly_q <= hr_q;
            d_q      <= cam_data;
        end
    end

    // Next-state logic for the frame FSM, pixel packing, counters and outputs.
    always_comb begin
        // NOTE: every _d starts from its _q (or idle value) so no path infers a latch.
        state_d       = state_q;
        skip_cnt_d    = skip_cnt_q;
        ph_d          = ph_q;
        x_d           = x_q;
        y_d           = y_q;
        pack_d        = pack_q;
        sof_pend_d    = sof_pend_q;
        crop_en_s_d   = crop_en_s_q;
        h_start_s_d   = h_start_s_q;
        h_end_s_d     = h_end_s_q;
        v_start_s_d   = v_start_s_q;
        v_end_s_d     = v_end_s_q;
        m_data_d      = m_data_q;
        m_wr_en_d     = 1'b0;
        m_sof_d       = 1'b0;
        line_done_d   = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_partial_d = 1'b0;

        // A line start restarts the beat phase and column for the beat now in d_q.
        ph_eff = hr_rise ? '0 : ph_q;
        x_eff  = hr_rise ? '0 : x_q;
        pix    = (pack_q << DATA_W) | PIX_W'(d_q);
        in_win = !crop_en_s_q ||
                 ((x_eff >= h_start_s_q) && (x_eff <= h_end_s_q) &&
                  (y_q >= v_start_s_q) && (y_q <= v_end_s_q));

        case (state_q)
            ST_SKIP: begin
                if (vs_rise) begin
                    if (skip_cnt_q == SKIP_W'(LAST_SKIP)) begin
                        state_d    = ST_WAIT_VS;
                        skip_cnt_d = '0;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT_VS: begin
                if (vs_fall) begin
                    crop_en_s_d = cfg_crop_en;
                    h_start_s_d = cfg_h_start;
                    h_end_s_d   = cfg_h_end;
                    v_start_s_d = cfg_v_start;
                    v_end_s_d   = cfg_v_end;
                    sof_pend_d  = 1'b1;
                    x_d         = '0;
                    y_d         = '0;
                    ph_d        = '0;
                    state_d     = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                if (vs_rise) begin
                    // Frame end wins over any line in progress.
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    y_d         = '0;
                    x_d         = '0;
                    ph_d        = '0;
                    sof_pend_d  = 1'b0;
                    state_d     = ST_WAIT_VS;
                end else if (hr_q) begin
                    pack_d = pix;
                    if (ph_eff == PH_W'(BYTES - 1)) begin
                        ph_d = '0;
                        x_d  = sat_inc(x_eff);
                        if (in_win) begin
                            m_data_d   = pix;
                            m_wr_en_d  = 1'b1;
                            m_sof_d    = sof_pend_q;
                            sof_pend_d = 1'b0;
                        end
                    end else begin
                        ph_d = ph_eff + 1'b1;
                        x_d  = x_eff;
                    end
                end else if (hr_fall) begin
                    line_done_d   = 1'b1;
                    err_partial_d = (ph_q != '0);
                    ph_d          = '0;
                    y_d           = sat_inc(y_q);
                end
            end

            default: state_d = ST_WAIT_VS;
        endcase
    end

    // Register FSM state, counters, window shadows and outputs.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            if (SKIP_FRAMES == 0) begin
                state_q <= ST_WAIT_VS;
            end else begin
                state_q <= ST_SKIP;
            end
            skip_cnt_q    <= '0;
            ph_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pack_q        <= '0;
            sof_pend_q    <= 1'b0;
            crop_en_s_q   <= 1'b0;
            h_start_s_q   <= '0;
            h_end_s_q     <= '0;
            v_start_s_q   <= '0;
            v_end_s_q     <= '0;
            m_data_q      <= '0;
            m_wr_en_q     <= 1'b0;
            m_sof_q       <= 1'b0;
            line_done_q   <= 1'b0;
            frame_cnt_q   <= '0;
            err_partial_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            ph_q          <= ph_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pack_q        <= pack_d;
            sof_pend_q    <= sof_pend_d;
            crop_en_s_q   <= crop_en_s_d;
            h_start_s_q   <= h_start_s_d;
            h_end_s_q     <= h_end_s_d;
            v_start_s_q   <= v_start_s_d;
            v_end_s_q     <= v_end_s_d;
            m_data_q      <= m_data_d;
            m_wr_en_q     <= m_wr_en_d;
            m_sof_q       <= m_sof_d;
            line_done_q   <= line_done_d;
            frame_cnt_q   <= frame_cnt_d;
            err_partial_q <= err_partial_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_wr_en     = m_wr_en_q;
    assign m_sof       = m_sof_q;
    assign line_done   = line_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_partial = err_partial_q;

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture. Instance A is the 8->16 bit path with
// two skipped frames; instance B is the 8->24 bit path with no skipping.
// Both share the sensor and configuration inputs.
module tb_cam_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cam_vsync, cam_href;
    logic [7:0]  cam_data;
    logic        cfg_crop_en;
    logic [11:0] cfg_h_start, cfg_h_end, cfg_v_start, cfg_v_end;

    logic [15:0] a_data;
    logic        a_wr, a_sof, a_ld, a_err;
    logic [15:0] a_fc;
    logic [23:0] b_data;
    logic        b_wr, b_sof, b_ld, b_err;
    logic [15:0] b_fc;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    cam_capture #(.DATA_W(8), .PIX_W(16), .CNT_W(12), .SKIP_FRAMES(2)) u_dut_a (
        .sclk(clk), .s_rst_n(rst_n),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .cfg_crop_en(cfg_crop_en), .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
        .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
        .m_data(a_data), .m_wr_en(a_wr), .m_sof(a_sof), .line_done(a_ld),
        .frame_cnt(a_fc), .err_partial(a_err)
    );

    cam_capture #(.DATA_W(8), .PIX_W(24), .CNT_W(12), .SKIP_FRAMES(0)) u_dut_b (
        .sclk(clk), .s_rst_n(rst_n),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .cfg_crop_en(cfg_crop_en), .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
        .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
        .m_data(b_data), .m_wr_en(b_wr), .m_sof(b_sof), .line_done(b_ld),
        .frame_cnt(b_fc), .err_partial(b_err)
    );

    // Event counters for instance A, sampled on the falling edge.
    int          wr_tot = 0, sof_tot = 0, ld_tot = 0, err_tot = 0, orphan_sof = 0;
    logic [15:0] sof_data = '0, last_data = '0;
    always @(negedge clk) begin
        if (a_wr) begin
            wr_tot++;
            last_data = a_data;
            if (a_sof) begin
                sof_tot++;
                sof_data = a_data;
            end
        end else if (a_sof) begin
            orphan_sof++;
        end
        if (a_ld)  ld_tot++;
        if (a_err) err_tot++;
    end

    // Crop vectors: window settings and the hand-derived response on a 4x4-pixel frame.
    typedef struct {
        logic        crop_en;
        logic [11:0] h_start, h_end, v_start, v_end;
        int          exp_wr;
        int          exp_x, exp_y;   // first emitted pixel, only meaningful when exp_wr > 0
    } crop_vec_t;
    crop_vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sensor byte i of line y: even bytes carry the pixel coordinates, odd bytes a marker.
    function automatic logic [7:0] byte_val(input int y, input int i);
        logic [7:0] b;
        if (i % 2 == 0) b = 8'(y * 16 + i / 2) ^ 8'hAB;
        else            b = 8'hCD;
        return b;
    endfunction

    function automatic logic [15:0] pix_val(input int x, input int y);
        logic [7:0] hi;
        hi = 8'(y * 16 + x) ^ 8'hAB;
        return {hi, 8'hCD};
    endfunction

    task automatic send_line(input int nbytes, input int y);
        for (int i = 0; i < nbytes; i++) begin
            cam_href = 1'b1;
            cam_data = byte_val(y, i);
            tick();
        end
        cam_href = 1'b0;
        cam_data = '0;
        repeat (4) tick();
    endtask

    task automatic send_frame(input int nlines, input int nbytes);
        for (int y = 0; y < nlines; y++) send_line(nbytes, y);
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_cfg(input logic en, input int hs, input int he, input int vs, input int ve);
        cfg_crop_en = en;
        cfg_h_start = 12'(hs);
        cfg_h_end   = 12'(he);
        cfg_v_start = 12'(vs);
        cfg_v_end   = 12'(ve);
    endtask

    // Bound the whole run in case the stimulus ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0, sof0, ld0, err0;

        vecs[0] = '{1'b0, 12'd0, 12'd0, 12'd0, 12'd0, 16, 0, 0};
        vecs[1] = '{1'b1, 12'd1, 12'd2, 12'd1, 12'd1, 2, 1, 1};
        vecs[2] = '{1'b1, 12'd3, 12'd1, 12'd0, 12'd3, 0, 0, 0};
        vecs[3] = '{1'b1, 12'd0, 12'd3, 12'd3, 12'd3, 4, 0, 3};
        vecs[4] = '{1'b1, 12'd3, 12'd7, 12'd0, 12'd0, 1, 3, 0};
        vecs[5] = '{1'b1, 12'd0, 12'd3, 12'd4, 12'd5, 0, 0, 0};
        vecs[6] = '{1'b1, 12'd2, 12'd2, 12'd0, 12'd3, 4, 2, 0};

        rst_n     = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = '0;
        set_cfg(1'b0, 0, 0, 0, 0);
        #1;
        check("reset a_data", a_data, 16'h0);
        check("reset a_wr", a_wr, 0);
        check("reset a_sof", a_sof, 0);
        check("reset a_ld", a_ld, 0);
        check("reset a_fc", a_fc, 0);
        check("reset a_err", a_err, 0);
        do_reset();

        // Width mode on B: 0x11, 0x22, 0x33 -> 0x112233, strobe 2 cycles after 0x33.
        vsync_pulse();
        cam_href = 1'b1;
        cam_data = 8'h11;
        tick();
        cam_data = 8'h22;
        tick();
        cam_data = 8'h33;
        tick();
        check("width wr at k+1", b_wr, 0);
        cam_href = 1'b0;
        cam_data = '0;
        tick();
        check("width wr at k+2", b_wr, 1);
        check("width data", b_data, 24'h112233);
        check("width ld early", b_ld, 0);
        tick();
        check("width ld at fall+2", b_ld, 1);
        check("width wr after", b_wr, 0);
        check("width data hold", b_data, 24'h112233);
        check("width err", b_err, 0);
        cam_vsync = 1'b1;
        tick();
        check("width fc at rise+1", b_fc, 0);
        tick();
        check("width fc at rise+2", b_fc, 1);
        cam_vsync = 1'b0;
        repeat (3) tick();

        // Skip + full frame on A: frames 1-2 skipped, frames 3-4 captured.
        do_reset();
        wr0 = wr_tot;
        ld0 = ld_tot;
        send_frame(4, 8);
        vsync_pulse();
        send_frame(4, 8);
        vsync_pulse();
        check("skip wr", wr_tot - wr0, 0);
        check("skip ld", ld_tot - ld0, 0);
        check("skip fc", a_fc, 0);
        for (int f = 3; f <= 4; f++) begin
            wr0 = wr_tot; sof0 = sof_tot; ld0 = ld_tot; err0 = err_tot;
            send_frame(4, 8);
            check($sformatf("frame%0d wr", f), wr_tot - wr0, 16);
            check($sformatf("frame%0d sof", f), sof_tot - sof0, 1);
            check($sformatf("frame%0d sof data", f), sof_data, 16'hABCD);
            check($sformatf("frame%0d ld", f), ld_tot - ld0, 4);
            check($sformatf("frame%0d err", f), err_tot - err0, 0);
            check($sformatf("frame%0d last data", f), last_data, pix_val(3, 3));
            vsync_pulse();
        end
        check("skip final fc", a_fc, 2);

        // Crop window table.
        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].crop_en, int'(vecs[i].h_start), int'(vecs[i].h_end),
                    int'(vecs[i].v_start), int'(vecs[i].v_end));
            vsync_pulse();
            wr0 = wr_tot; sof0 = sof_tot; ld0 = ld_tot; err0 = err_tot;
            send_frame(4, 8);
            check($sformatf("crop[%0d] wr", i), wr_tot - wr0, vecs[i].exp_wr);
            check($sformatf("crop[%0d] sof", i), sof_tot - sof0, (vecs[i].exp_wr > 0) ? 1 : 0);
            if (vecs[i].exp_wr > 0)
                check($sformatf("crop[%0d] sof data", i), sof_data, pix_val(vecs[i].exp_x, vecs[i].exp_y));
            check($sformatf("crop[%0d] ld", i), ld_tot - ld0, 4);
            check($sformatf("crop[%0d] err", i), err_tot - err0, 0);
        end
        check("crop fc", a_fc, 9);

        // Mid-frame config change: old window for this frame, new one for the next.
        set_cfg(1'b1, 0, 3, 0, 3);
        vsync_pulse();
        wr0 = wr_tot;
        send_frame(2, 8);
        cfg_h_end = 12'd0;
        send_line(8, 2);
        send_line(8, 3);
        check("cfgchg old window wr", wr_tot - wr0, 16);
        vsync_pulse();
        wr0 = wr_tot; sof0 = sof_tot;
        send_frame(4, 8);
        check("cfgchg new window wr", wr_tot - wr0, 4);
        check("cfgchg new sof", sof_tot - sof0, 1);
        check("cfgchg new last data", last_data, pix_val(0, 3));

        // Partial pixel: 7 bytes -> 3 pixels, one err_partial, one line_done.
        set_cfg(1'b0, 0, 0, 0, 0);
        vsync_pulse();
        wr0 = wr_tot; ld0 = ld_tot; err0 = err_tot;
        send_line(7, 0);
        check("partial wr", wr_tot - wr0, 3);
        check("partial err", err_tot - err0, 1);
        check("partial ld", ld_tot - ld0, 1);
        wr0 = wr_tot; err0 = err_tot;
        send_line(8, 1);
        check("after partial wr", wr_tot - wr0, 4);
        check("after partial err", err_tot - err0, 0);
        check("after partial last data", last_data, pix_val(3, 1));

        // vsync rising while href is high: frame end wins, no line_done.
        vsync_pulse();
        check("abort fc before", a_fc, 13);
        wr0 = wr_tot; ld0 = ld_tot; err0 = err_tot;
        cam_href = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cam_data = byte_val(0, i);
            tick();
        end
        cam_data  = byte_val(0, 5);
        cam_vsync = 1'b1;
        repeat (2) tick();
        cam_href = 1'b0;
        cam_data = '0;
        repeat (2) tick();
        cam_vsync = 1'b0;
        repeat (4) tick();
        check("abort wr", wr_tot - wr0, 2);
        check("abort ld", ld_tot - ld0, 0);
        check("abort err", err_tot - err0, 0);
        check("abort fc", a_fc, 14);

        // Reset in the middle of a line clears outputs at once and restarts skipping.
        cam_href = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cam_data = byte_val(0, i);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst data", a_data, 16'h0);
        check("midrst wr", a_wr, 0);
        check("midrst sof", a_sof, 0);
        check("midrst ld", a_ld, 0);
        check("midrst fc", a_fc, 0);
        check("midrst err", a_err, 0);
        cam_href = 1'b0;
        cam_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        wr0 = wr_tot; ld0 = ld_tot;
        send_frame(4, 8);
        vsync_pulse();
        send_frame(4, 8);
        vsync_pulse();
        check("reskip wr", wr_tot - wr0, 0);
        check("reskip ld", ld_tot - ld0, 0);
        check("reskip fc", a_fc, 0);
        wr0 = wr_tot; sof0 = sof_tot;
        send_frame(4, 8);
        check("reskip active wr", wr_tot - wr0, 16);
        check("reskip active sof", sof_tot - sof0, 1);
        vsync_pulse();
        check("reskip active fc", a_fc, 1);
        check("no orphan sof", orphan_sof, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
